// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: forwarding selects and hazard-unit FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    HALTED
  } hu_state_t;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of hazard-unit signals with views for the unit and for a driver/monitor.
interface hazard_ctrl_unit_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input logic CLK
);
  logic              RST;
  logic              ihit, dhit, dmem_req, branch_taken, halt;
  logic [REG_AW-1:0] rs_id, rt_id, rs_ex, rt_ex, wsel_ex, wsel_mem, wsel_wb;
  logic              wen_ex, memren_ex, wen_mem, wen_wb;
  logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic              flush_ifid, flush_idex, flush_exmem, halted;
  fwd_sel_t          fwd_a, fwd_b;

  modport hu (
    input  CLK, RST, ihit, dhit, dmem_req, branch_taken, halt,
    input  rs_id, rt_id, rs_ex, rt_ex, wsel_ex, wsel_mem, wsel_wb,
    input  wen_ex, memren_ex, wen_mem, wen_wb,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output flush_ifid, flush_idex, flush_exmem, halted, fwd_a, fwd_b
  );

  modport tb (
    input  CLK,
    output RST, ihit, dhit, dmem_req, branch_taken, halt,
    output rs_id, rt_id, rs_ex, rt_ex, wsel_ex, wsel_mem, wsel_wb,
    output wen_ex, memren_ex, wen_mem, wen_wb,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  flush_ifid, flush_idex, flush_exmem, halted, fwd_a, fwd_b
  );
endinterface

// File: rtl/fwd_select.sv
// Picks the youngest in-flight producer of one EX source register; r0 is never forwarded.
module fwd_select
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] wsel_mem,
  input  logic              wen_mem,
  input  logic [REG_AW-1:0] wsel_wb,
  input  logic              wen_wb,
  output fwd_sel_t          sel
);
  always_comb begin
    sel = FWD_NONE;
    if (wen_mem && (wsel_mem != '0) && (wsel_mem == src)) begin
      sel = FWD_MEM;
    end else if (wen_wb && (wsel_wb != '0) && (wsel_wb == src)) begin
      sel = FWD_WB;
    end
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// 5-stage pipeline hazard controller: latch enables/flushes, multi-cycle load-use stall,
// cache-miss freeze, branch flush and sticky halt, plus EX operand forwarding selects.
module hazard_ctrl_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned BR_STAGE       = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dmem_req,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic [REG_AW-1:0] rs_ex,
  input  logic [REG_AW-1:0] rt_ex,
  input  logic [REG_AW-1:0] wsel_ex,
  input  logic              wen_ex,
  input  logic              memren_ex,
  input  logic [REG_AW-1:0] wsel_mem,
  input  logic              wen_mem,
  input  logic [REG_AW-1:0] wsel_wb,
  input  logic              wen_wb,
  input  logic              branch_taken,
  input  logic              halt,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output fwd_sel_t          fwd_a,
  output fwd_sel_t          fwd_b,
  output logic              halted
);
  hu_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fwd_sel_t         fwd_a_raw, fwd_b_raw;
  logic             load_use;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src(rs_ex), .wsel_mem(wsel_mem), .wen_mem(wen_mem),
    .wsel_wb(wsel_wb), .wen_wb(wen_wb), .sel(fwd_a_raw)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src(rt_ex), .wsel_mem(wsel_mem), .wen_mem(wen_mem),
    .wsel_wb(wsel_wb), .wen_wb(wen_wb), .sel(fwd_b_raw)
  );

  assign fwd_a = RST ? FWD_NONE : fwd_a_raw;
  assign fwd_b = RST ? FWD_NONE : fwd_b_raw;

  assign load_use = memren_ex && wen_ex && (wsel_ex != '0) &&
                    ((wsel_ex == rs_id) || (wsel_ex == rt_id));

  // Prioritised event decode: outputs for this cycle and the next FSM state.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (RST) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == HALTED) begin
      halted = 1'b1;
    end else if (halt) begin
      state_d = HALTED;
    end else if (dmem_req && !dhit) begin
      // Frozen: everything holds, including a pending load-use count.
      state_d = state_q;
    end else if (branch_taken) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = (BR_STAGE == 3);
      state_d     = RUN;
      cnt_d       = '0;
    end else if ((state_q == LDSTALL) || load_use) begin
      {idex_en, exmem_en, memwb_en} = 3'b111;
      flush_idex = 1'b1;
      if (state_q == LDSTALL) begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (LOAD_USE_STALL > 1) begin
        state_d = LDSTALL;
        cnt_d   = CNT_W'(LOAD_USE_STALL - 1);
      end
    end else if (!ihit) begin
      {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
      flush_ifid = 1'b1;
    end else begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three parameterisations share one stimulus bus.
module tb_hazard_ctrl_unit;

  logic       CLK, RST;
  logic       ihit, dhit, dmem_req, branch_taken, halt;
  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, wsel_ex, wsel_mem, wsel_wb;
  logic       wen_ex, memren_ex, wen_mem, wen_wb;

  logic [8:0] out_a, out_b, out_c;
  logic [1:0] fa_a, fb_a, fa_b, fb_b, fa_c, fb_c;
  logic       pa, ia, da, ea, ma, fia, fda, fea, ha;
  logic       pb, ib, db, eb, mb, fib, fdb, feb, hb;
  logic       pc, ic, dc, ec, mc, fic, fdc, fec, hc;

  localparam logic [8:0] EN_RUN = 9'b11111_000_0;
  localparam logic [8:0] BUB_LU = 9'b00111_010_0;
  localparam logic [8:0] BUB_IF = 9'b01111_100_0;
  localparam logic [8:0] FREEZE = 9'b00000_000_0;
  localparam logic [8:0] BR3    = 9'b11111_111_0;
  localparam logic [8:0] BR2    = 9'b11111_110_0;
  localparam logic [8:0] HALTD  = 9'b00000_000_1;

  int total = 0;
  int bad   = 0;

  // a: 1 bubble, branch in MEM; b: 3 bubbles, branch in MEM; c: 2 bubbles, branch in EX
  hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_STALL(1), .BR_STAGE(3)) u_a (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .wsel_ex(wsel_ex), .wen_ex(wen_ex), .memren_ex(memren_ex),
    .wsel_mem(wsel_mem), .wen_mem(wen_mem), .wsel_wb(wsel_wb), .wen_wb(wen_wb),
    .branch_taken(branch_taken), .halt(halt),
    .pc_en(pa), .ifid_en(ia), .idex_en(da), .exmem_en(ea), .memwb_en(ma),
    .flush_ifid(fia), .flush_idex(fda), .flush_exmem(fea),
    .fwd_a(fa_a), .fwd_b(fb_a), .halted(ha)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_STALL(3), .BR_STAGE(3)) u_b (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .wsel_ex(wsel_ex), .wen_ex(wen_ex), .memren_ex(memren_ex),
    .wsel_mem(wsel_mem), .wen_mem(wen_mem), .wsel_wb(wsel_wb), .wen_wb(wen_wb),
    .branch_taken(branch_taken), .halt(halt),
    .pc_en(pb), .ifid_en(ib), .idex_en(db), .exmem_en(eb), .memwb_en(mb),
    .flush_ifid(fib), .flush_idex(fdb), .flush_exmem(feb),
    .fwd_a(fa_b), .fwd_b(fb_b), .halted(hb)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_STALL(2), .BR_STAGE(2)) u_c (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .wsel_ex(wsel_ex), .wen_ex(wen_ex), .memren_ex(memren_ex),
    .wsel_mem(wsel_mem), .wen_mem(wen_mem), .wsel_wb(wsel_wb), .wen_wb(wen_wb),
    .branch_taken(branch_taken), .halt(halt),
    .pc_en(pc), .ifid_en(ic), .idex_en(dc), .exmem_en(ec), .memwb_en(mc),
    .flush_ifid(fic), .flush_idex(fdc), .flush_exmem(fec),
    .fwd_a(fa_c), .fwd_b(fb_c), .halted(hc)
  );

  assign out_a = {pa, ia, da, ea, ma, fia, fda, fea, ha};
  assign out_b = {pb, ib, db, eb, mb, fib, fdb, feb, hb};
  assign out_c = {pc, ic, dc, ec, mc, fic, fdc, fec, hc};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       ihit, dmem_req, dhit, br, memren, wen_ex;
    logic [4:0] wsel_ex, rs_id, rt_id;
    logic       wen_mem;
    logic [4:0] wsel_mem;
    logic       wen_wb;
    logic [4:0] wsel_wb, rs_ex, rt_ex;
    logic [8:0] exp_out;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    rs_id = '0; rt_id = '0; rs_ex = '0; rt_ex = '0;
    wsel_ex = '0; wsel_mem = '0; wsel_wb = '0;
    wen_ex = 1'b0; memren_ex = 1'b0; wen_mem = 1'b0; wen_wb = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
  endtask

  task automatic set_load_use();
    memren_ex = 1'b1; wen_ex = 1'b1; wsel_ex = 5'd8; rs_id = 5'd8;
  endtask

  initial begin
    //          name          ih   dreq dhit br   mr   wex  wsel   rsid   rtid   wm   wselm  ww   wselw  rsex   rtex   out     fa     fb
    tbl[0]  = '{"run",        1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  EN_RUN, 2'b00, 2'b00};
    tbl[1]  = '{"ibub",       1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  BUB_IF, 2'b00, 2'b00};
    tbl[2]  = '{"lu_rs",      1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,5'd8,  5'd8,  5'd0,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  BUB_LU, 2'b00, 2'b00};
    tbl[3]  = '{"lu_rt_noih", 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,5'd7,  5'd1,  5'd7,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  BUB_LU, 2'b00, 2'b00};
    tbl[4]  = '{"lu_r0",      1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,5'd0,  5'd0,  5'd0,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  EN_RUN, 2'b00, 2'b00};
    tbl[5]  = '{"alu_dep",    1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd8,  5'd8,  5'd0,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  EN_RUN, 2'b00, 2'b00};
    tbl[6]  = '{"br_over_lu", 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,5'd8,  5'd8,  5'd0,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  BR3,    2'b00, 2'b00};
    tbl[7]  = '{"freeze_br",  1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  FREEZE, 2'b00, 2'b00};
    tbl[8]  = '{"dmem_hit",   1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  EN_RUN, 2'b00, 2'b00};
    tbl[9]  = '{"fwd_mem",    1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b1,5'd5,  1'b1,5'd5,  5'd5,  5'd0,  EN_RUN, 2'b01, 2'b00};
    tbl[10] = '{"fwd_r0",     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b1,5'd0,  1'b1,5'd0,  5'd0,  5'd0,  EN_RUN, 2'b00, 2'b00};
    tbl[11] = '{"fwd_wb",     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b1,5'd3,  1'b1,5'd9,  5'd3,  5'd9,  EN_RUN, 2'b01, 2'b10};
    tbl[12] = '{"fwd_nowenm", 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,5'd9,  1'b1,5'd9,  5'd4,  5'd9,  EN_RUN, 2'b00, 2'b10};
    tbl[13] = '{"fwd_off",    1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,5'd9,  1'b0,5'd9,  5'd9,  5'd9,  EN_RUN, 2'b00, 2'b00};
    tbl[14] = '{"freeze_lu",  1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,5'd8,  5'd8,  5'd0,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  5'd0,  FREEZE, 2'b00, 2'b00};

    // Reset dominates a pending branch and live forwarding matches
    idle_inputs();
    RST = 1'b1; branch_taken = 1'b1;
    wen_mem = 1'b1; wsel_mem = 5'd5; rs_ex = 5'd5; rt_ex = 5'd5;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk("rst_out_a", out_a, FREEZE);
      chk("rst_out_b", out_b, FREEZE);
      chk("rst_out_c", out_c, FREEZE);
      chk("rst_fwd", 9'({fa_a, fb_a}), 9'd0);
      next_cycle();
    end
    RST = 1'b0;
    idle_inputs();

    // Single-cycle decode on the 1-bubble instance, which never leaves RUN here
    for (int i = 0; i < 15; i++) begin
      ihit = tbl[i].ihit; dmem_req = tbl[i].dmem_req; dhit = tbl[i].dhit;
      branch_taken = tbl[i].br; memren_ex = tbl[i].memren; wen_ex = tbl[i].wen_ex;
      wsel_ex = tbl[i].wsel_ex; rs_id = tbl[i].rs_id; rt_id = tbl[i].rt_id;
      wen_mem = tbl[i].wen_mem; wsel_mem = tbl[i].wsel_mem;
      wen_wb = tbl[i].wen_wb; wsel_wb = tbl[i].wsel_wb;
      rs_ex = tbl[i].rs_ex; rt_ex = tbl[i].rt_ex;
      @(negedge CLK);
      chk({tbl[i].name, "_out"}, out_a, tbl[i].exp_out);
      chk({tbl[i].name, "_fa"}, 9'(fa_a), 9'(tbl[i].exp_fa));
      chk({tbl[i].name, "_fb"}, 9'(fb_a), 9'(tbl[i].exp_fb));
      next_cycle();
    end

    // Load-use bubble counts: a=1, c=2, b=3
    do_reset();
    set_load_use();
    @(negedge CLK);
    chk("lu0_a", out_a, BUB_LU);
    chk("lu0_b", out_b, BUB_LU);
    chk("lu0_c", out_c, BUB_LU);
    next_cycle(); idle_inputs();
    @(negedge CLK);
    chk("lu1_a", out_a, EN_RUN);
    chk("lu1_b", out_b, BUB_LU);
    chk("lu1_c", out_c, BUB_LU);
    next_cycle();
    @(negedge CLK);
    chk("lu2_b", out_b, BUB_LU);
    chk("lu2_c", out_c, EN_RUN);
    next_cycle();
    @(negedge CLK);
    chk("lu3_b", out_b, EN_RUN);

    // Data-cache miss freezes a stall in progress without consuming it
    do_reset();
    set_load_use();
    @(negedge CLK);
    chk("frz_det_b", out_b, BUB_LU);
    next_cycle(); idle_inputs();
    dmem_req = 1'b1; dhit = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("frz_a", out_a, FREEZE);
      chk("frz_b", out_b, FREEZE);
      chk("frz_c", out_c, FREEZE);
      next_cycle();
    end
    dhit = 1'b1;
    @(negedge CLK);
    chk("thaw0_a", out_a, EN_RUN);
    chk("thaw0_b", out_b, BUB_LU);
    chk("thaw0_c", out_c, BUB_LU);
    next_cycle();
    @(negedge CLK);
    chk("thaw1_b", out_b, BUB_LU);
    chk("thaw1_c", out_c, EN_RUN);
    next_cycle();
    @(negedge CLK);
    chk("thaw2_b", out_b, EN_RUN);

    // Branch cancels a load-use stall; flush depth follows the resolve stage
    do_reset();
    set_load_use();
    @(negedge CLK);
    chk("brs_det_c", out_c, BUB_LU);
    next_cycle(); idle_inputs();
    branch_taken = 1'b1; ihit = 1'b0;
    @(negedge CLK);
    chk("brs_b", out_b, BR3);
    chk("brs_c", out_c, BR2);
    next_cycle(); idle_inputs();
    @(negedge CLK);
    chk("brs_after_b", out_b, EN_RUN);
    chk("brs_after_c", out_c, EN_RUN);

    // Sticky halt, released only by reset
    do_reset();
    halt = 1'b1; ihit = 1'b0;
    @(negedge CLK);
    chk("halt_memwb_a", 9'(ma), 9'd0);
    chk("halt_flag_a", 9'(ha), 9'd0);
    next_cycle(); idle_inputs();
    for (int c = 0; c < 20; c++) begin
      branch_taken = c[0];
      @(negedge CLK);
      chk("halted_a", out_a, HALTD);
      chk("halted_c", out_c, HALTD);
      next_cycle();
    end
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    chk("halt_rst_a", out_a, FREEZE);
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    chk("halt_cleared_a", out_a, EN_RUN);
    chk("halt_cleared_b", out_b, EN_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
